// File: rtl/axi_line_read_master.sv
// axi_line_read_master: AXI4 read master that refills one cache line (or a single beat) per request
module axi_line_read_master #(
  parameter int MASTER_ID = 0,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int LEN_W = 4,
  parameter int BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic                    req_line,
  input  logic                    hold_off,
  output logic                    busy,
  output logic                    line_valid,
  output logic [BEATS*DATA_W-1:0] line_data,
  output logic                    line_err,
  output logic [ID_W-1:0]         ARID_M,
  output logic [ADDR_W-1:0]       ARADDR_M,
  output logic [LEN_W-1:0]        ARLEN_M,
  output logic [2:0]              ARSIZE_M,
  output logic [1:0]              ARBURST_M,
  output logic                    ARVALID_M,
  input  logic                    ARREADY_M,
  input  logic [ID_W-1:0]         RID_M,
  input  logic [DATA_W-1:0]       RDATA_M,
  input  logic [1:0]              RRESP_M,
  input  logic                    RLAST_M,
  input  logic                    RVALID_M,
  output logic                    RREADY_M
);
  localparam int CW = $clog2(BEATS) + 1;
  localparam int XW = LEN_W + 1;
  localparam logic [ID_W-1:0] MID = ID_W'(MASTER_ID);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS * DATA_W / 8 - 1);
  localparam logic [ADDR_W-1:0] BEAT_MASK = ~ADDR_W'(DATA_W / 8 - 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [XW-1:0] cnt_x, len_x;
  logic err, ar_held, beat, store, early, late, bad;
  assign ARID_M = MID;
  assign ARSIZE_M = 3'($clog2(DATA_W / 8));
  assign ARBURST_M = 2'b01;
  assign cnt_x = XW'(cnt);
  assign len_x = {1'b0, ARLEN_M};
  assign beat = state == DATA && RVALID_M;
  assign store = beat && cnt_x <= len_x;
  assign early = RLAST_M && cnt_x < len_x;
  assign late = !RLAST_M && cnt_x == len_x;
  assign bad = RRESP_M != 2'b00 || RID_M != MID || early || late;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign RREADY_M = state == DATA;
  // once raised, ARVALID ignores hold_off until the handshake completes
  assign ARVALID_M = state == ADDR && (ar_held || !hold_off);
  assign line_valid = state == DONE;
  assign line_err = state == DONE && err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = req_valid ? ADDR : IDLE;
      ADDR: state_nx = ARVALID_M && ARREADY_M ? DATA : ADDR;
      DATA: state_nx = beat && RLAST_M ? DONE : DATA;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
      ar_held <= 1'b0;
      ARADDR_M <= '0;
      ARLEN_M <= '0;
      line_data <= '0;
    end else begin
      ar_held <= ARVALID_M && !ARREADY_M;
      if (state == IDLE && req_valid) begin
        ARADDR_M <= req_addr & (req_line ? LINE_MASK : BEAT_MASK);
        ARLEN_M <= req_line ? LEN_W'(BEATS - 1) : '0;
        cnt <= '0;
        err <= 1'b0;
        line_data <= '0;
      end
      if (beat) begin
        cnt <= &cnt ? cnt : cnt + CW'(1);
        err <= err | bad;
      end
      // beats past ARLEN are consumed but never stored
      for (int k = 0; k < BEATS; k++)
        if (store && cnt == CW'(k)) line_data[k*DATA_W +: DATA_W] <= RDATA_M;
    end
  end
endmodule

// File: tb/tb_axi_line_read_master.sv
// tb_axi_line_read_master: directed plus randomized refill traffic against a queue-free transaction model
module tb_axi_line_read_master;
  localparam int ADDR_W = 32, DATA_W = 32, ID_W = 4, LEN_W = 4, BEATS = 4, MASTER_ID = 0;
  localparam int LW = BEATS * DATA_W;
  logic clk = 0, rst = 0;
  logic req_valid, req_ready, req_line, hold_off, busy, line_valid, line_err;
  logic [ADDR_W-1:0] req_addr, ARADDR_M;
  logic [LW-1:0] line_data;
  logic [ID_W-1:0] ARID_M, RID_M;
  logic [LEN_W-1:0] ARLEN_M;
  logic [2:0] ARSIZE_M;
  logic [1:0] ARBURST_M, RRESP_M;
  logic ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;
  logic [DATA_W-1:0] RDATA_M;
  int vecs = 0, errs = 0, lv_cnt = 0, n_done = 0;

  axi_line_read_master #(.MASTER_ID(MASTER_ID), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .LEN_W(LEN_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_line(req_line), .hold_off(hold_off), .busy(busy), .line_valid(line_valid),
    .line_data(line_data), .line_err(line_err), .ARID_M(ARID_M), .ARADDR_M(ARADDR_M),
    .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M),
    .ARREADY_M(ARREADY_M), .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M),
    .RLAST_M(RLAST_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M));

  always #5 clk = ~clk;
  always @(negedge clk) if (line_valid === 1'b1) lv_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 clean, 1 bad RRESP on beat e, 2 RLAST early on beat e, 3 bad RID on beat e, 4 RLAST late
  task automatic txn(input logic [ADDR_W-1:0] a, input bit line, input int hold, input int ard,
                     input int gmax, input int mode, input int e, input int abort, input bit zw,
                     input int base);
    int n, sent, last_at, h, d, g, ed;
    bit raised, hs, exp_err;
    logic [DATA_W-1:0] dat [BEATS+3];
    logic [1:0] rsp [BEATS+3];
    logic [ID_W-1:0] rid [BEATS+3];
    logic [ADDR_W-1:0] exp_addr;
    logic [LW-1:0] exp_line;
    n = line ? BEATS : 1;
    sent = n;
    last_at = n - 1;
    if (mode == 2 && e < n - 1) begin sent = e + 1; last_at = e; end
    if (mode == 4) begin sent = n + 1 + e % 2; last_at = sent - 1; end
    exp_err = last_at != n - 1;
    exp_line = '0;
    for (int i = 0; i < sent; i++) begin
      dat[i] = base < 0 ? DATA_W'($urandom) : DATA_W'(base + i);
      rsp[i] = (mode == 1 && i == e % sent) ? 2'($urandom_range(1, 3)) : 2'b00;
      rid[i] = (mode == 3 && i == e % sent) ? ID_W'(MASTER_ID + 1 + $urandom_range(0, 13)) : ID_W'(MASTER_ID);
      if (rsp[i] != 2'b00 || rid[i] != ID_W'(MASTER_ID)) exp_err = 1;
      if (i < n) exp_line[i*DATA_W +: DATA_W] = dat[i];
    end
    exp_addr = line ? a - a % (BEATS * DATA_W / 8) : a - a % (DATA_W / 8);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    chk("busy_idle", busy, 0);
    req_valid = 1; req_addr = a; req_line = line; hold_off = hold > 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_line = 1'($urandom);
    chk("busy", busy, 1);
    chk("req_ready_busy", req_ready, 0);
    h = hold; d = ard; raised = 0; hs = 0; ed = 0;
    for (int c = 0; c < 64 && !hs; c++) begin
      if (c > 0) @(negedge clk);
      hold_off = h > 0;
      #1;
      chk("arvalid", ARVALID_M, raised || h == 0);
      chk("rready_addr", RREADY_M, 0);
      if (ARVALID_M === 1'b1) begin
        raised = 1;
        chk("araddr", ARADDR_M, exp_addr);
        chk("arlen", ARLEN_M, n - 1);
        chk("arsize", ARSIZE_M, 2);
        chk("arburst", ARBURST_M, 1);
        chk("arid", ARID_M, MASTER_ID);
        ARREADY_M = d == 0;
        if (d > 0) d--;
      end else ARREADY_M = 0;
      hs = ARVALID_M === 1'b1 && ARREADY_M;
      @(posedge clk);
      ed++;
      if (h > 0) h--;
    end
    @(negedge clk);
    ARREADY_M = 0; hold_off = 0;
    chk("ar_handshake", hs, 1);
    if (!hs) return;
    for (int i = 0; i < sent; i++) begin
      g = $urandom_range(0, gmax);
      repeat (g) begin @(posedge clk); ed++; @(negedge clk); end
      RVALID_M = 1; RDATA_M = dat[i]; RID_M = rid[i]; RRESP_M = rsp[i]; RLAST_M = i == last_at;
      #1;
      chk("rready", RREADY_M, 1);
      @(posedge clk);
      ed++;
      @(negedge clk);
      RVALID_M = 0; RLAST_M = 0; RDATA_M = $urandom; RRESP_M = 0; RID_M = ID_W'(MASTER_ID);
      if (i + 1 == abort) begin
        rst = 0;
        #1;
        chk("rst_arvalid", ARVALID_M, 0);
        chk("rst_rready", RREADY_M, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_line_data", line_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        return;
      end
    end
    chk("line_valid", line_valid, 1);
    chk("line_err", line_err, exp_err);
    chk("line_data", line_data, exp_line);
    if (zw) chk("latency", ed, n + 1);
    n_done++;
    @(negedge clk);
    chk("line_valid_pulse", line_valid, 0);
    chk("line_data_hold", line_data, exp_line);
  endtask

  initial begin
    int lv0, m, mode;
    req_valid = 0; req_addr = 0; req_line = 0; hold_off = 0; ARREADY_M = 0;
    RID_M = ID_W'(MASTER_ID); RDATA_M = 0; RRESP_M = 0; RLAST_M = 0; RVALID_M = 0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid0", ARVALID_M, 0);
    chk("rst_rready0", RREADY_M, 0);
    chk("rst_line_valid0", line_valid, 0);
    chk("rst_line_err0", line_err, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_line_data0", line_data, 0);
    chk("rst_araddr0", ARADDR_M, 0);
    chk("rst_arlen0", ARLEN_M, 0);
    chk("rst_arsize0", ARSIZE_M, 2);
    chk("rst_arburst0", ARBURST_M, 1);
    chk("rst_arid0", ARID_M, MASTER_ID);
    rst = 1;
    txn(32'h0000_1014, 1, 0, 0, 0, 0, 0, -1, 1, 'hA0);
    txn(32'h0000_2002, 0, 0, 0, 0, 0, 0, -1, 1, 'h55);
    txn(32'h0000_3008, 1, 5, 3, 0, 0, 0, -1, 0, -1);
    txn(32'h0000_4000, 1, 0, 0, 0, 1, 2, -1, 0, -1);
    txn(32'h0000_5000, 1, 0, 0, 0, 2, 1, -1, 0, -1);
    txn(32'h0000_6004, 1, 0, 1, 1, 3, 0, -1, 0, -1);
    txn(32'h0000_7000, 1, 0, 0, 1, 4, 1, -1, 0, -1);
    txn(32'h0000_8001, 0, 2, 1, 0, 4, 0, -1, 0, -1);
    @(negedge clk);
    lv0 = lv_cnt;
    txn(32'h0000_9000, 1, 0, 0, 0, 0, 0, 2, 0, -1);
    @(negedge clk);
    chk("no_line_valid_on_reset", lv_cnt, lv0);
    txn(32'h0000_A010, 1, 0, 0, 0, 0, 0, -1, 1, -1);
    for (int r = 0; r < 200; r++) begin
      m = $urandom_range(0, 9);
      mode = m < 6 ? 0 : m - 5;
      txn($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), 2,
          mode, $urandom_range(0, BEATS), -1, 0, -1);
    end
    @(negedge clk);
    @(negedge clk);
    chk("line_valid_count", lv_cnt, n_done);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
